query_dispatcher: RTL and testbench
===================================

Name: query_dispatcher

Overview:
- Schedules queries arriving from the stream input handler across NUM_ENGINES Smith-Waterman engines.
- Accepts a query-info beat, then selects a free engine by round-robin.
- Forwards the info beat, followed by all query sequence blocks of that query, to the selected engine only.
- Tracks per-engine busy state until each engine pulses done.

Parameters:
NUM_ENGINES, 4, number of engines served (2..16)
ENG_IDX_W, 2, width of engine index; must equal ceil(log2(NUM_ENGINES))
NUM_PES, 64, PEs per engine; query bp per block (power of two, 16..256)

Ports:
clk  in  1  engine clock; single clock domain
rst  in  1  reset; synchronous, active-high
ref_length_in  in  28  reference length (128bp blocks)
ref_addr_in  in  28  reference address
query_length_in  in  16  query length (bp)
query_id_in  in  16  query ID
cell_score_threshold_in  in  32  report threshold
query_info_valid_in  in  1  info beat valid
query_info_rdy_out  out  1  info beat accepted
query_seq_block_in  in  NUM_PES*2  query block
query_seq_block_valid_in  in  1  block valid
query_seq_block_rdy_out  out  1  block accepted
eng_ref_length_out, eng_ref_addr_out, eng_query_length_out, eng_query_id_out, eng_cell_score_threshold_out  out  28/28/16/16/32  info fields broadcast to all engines (combinational copy of inputs)
eng_query_seq_block_out  out  NUM_PES*2  block broadcast to all engines
eng_info_valid_out  out  NUM_ENGINES  one-hot info valid
eng_info_rdy_in  in  NUM_ENGINES  per-engine info ready
eng_seq_block_valid_out  out  NUM_ENGINES  one-hot block valid
eng_seq_block_rdy_in  in  NUM_ENGINES  per-engine block ready
eng_done_in  in  NUM_ENGINES  one-cycle pulse: engine finished its query
eng_busy_out  out  NUM_ENGINES  registered busy flags
active_engine_out  out  ENG_IDX_W  engine currently being fed
protocol_err_out  out  1  sticky protocol error flag

Behaviour:
- Reset state: IDLE. busy=0, rr_ptr=0, sel=0, block_cnt=0, num_blocks=0, protocol_err_out=0.
- Valid/rdy outputs are decoded from state, so all of them are 0 during reset.

FSM state IDLE:
- query_info_rdy_out=0 and query_seq_block_rdy_out=0.
- When query_info_valid_in=1 and any busy bit is 0:
  - sel = first non-busy engine scanning rr_ptr, rr_ptr+1, ... modulo NUM_ENGINES.
  - busy[sel]<=1 and rr_ptr<=sel+1 (mod NUM_ENGINES).
  - num_blocks <= ceil(query_length_in/NUM_PES), i.e. query_length_in>>log2(NUM_PES), plus 1 if the low bits are nonzero.
  - block_cnt<=0; go to SEND_INFO.
- When all engines are busy: stay in IDLE and stall (rdy held low).
- Minimum one cycle spent in IDLE between queries.

FSM state SEND_INFO:
- eng_info_valid_out[sel]=query_info_valid_in; query_info_rdy_out=eng_info_rdy_in[sel]; all other bits 0.
- On handshake: go to IDLE if num_blocks==0, else go to SEND_BLOCKS.

FSM state SEND_BLOCKS:
- eng_seq_block_valid_out[sel]=query_seq_block_valid_in; query_seq_block_rdy_out=eng_seq_block_rdy_in[sel].
- Each handshake increments block_cnt.
- The handshake on which block_cnt==num_blocks-1 returns to IDLE.

Done handling:
- eng_done_in[i] clears busy[i] at the next edge.
- Done on an engine with busy[i]=0 is ignored.
- Done on sel while state is SEND_INFO or SEND_BLOCKS is ignored and sets protocol_err_out (sticky until rst).
- Done on engine i in the same cycle IDLE selects i cannot occur, because i must be non-busy to be selected.
- Done on one engine and selection of a different engine in the same cycle: both take effect.
- A done in a cycle makes that engine selectable from the following cycle.

Other rules:
- Info fields and block data pass through combinationally: zero-cycle latency, no data registers.
- active_engine_out=sel in all states.
- The dispatcher never drops or reorders beats; backpressure from the selected engine propagates directly upstream.
- Counter widths: num_blocks and block_cnt are 17-log2(NUM_PES) bits.
- rst mid-dispatch: returns to IDLE and clears all busy bits. Upstream must also be reset; a partially sent query is abandoned.

Test Plan:
- Reset, then info with query_length=130 (NUM_PES=64), all ready=1 -> engine 0 receives the info beat and 3 blocks; busy=0001; active_engine_out=0; FSM back in IDLE.
- Four back-to-back 64bp queries, no done -> engines 0,1,2,3 in order, busy=1111. Fifth info is held with rdy=0. done[2] pulse -> fifth query goes to engine 2.
- query_length=0 -> info beat only, no block handshake, FSM returns to IDLE after SEND_INFO; query_length=64 -> exactly 1 block; query_length=65 -> 2 blocks.
- eng_seq_block_rdy_in[sel] toggled 1/0 every cycle during a 5-block query -> query_seq_block_rdy_out mirrors it, exactly 5 handshakes, no other engine sees valid.
- done[sel] during SEND_BLOCKS -> protocol_err_out=1 and stays 1; busy[sel] stays 1; done on an idle engine -> no change.
- rst asserted after 2 of 4 blocks -> next cycle: state IDLE, busy=0, all valid/rdy=0, rr_ptr=0.

Source files
------------

// File: rtl/query_dispatcher_if.sv
// query_dispatcher_if: upstream query info/block stream plus per-engine fan-out bus; slave=dispatcher, master=upstream+engines
interface query_dispatcher_if #(
  parameter int NUM_ENGINES = 4,
  parameter int ENG_IDX_W = 2,
  parameter int NUM_PES = 64
);
  logic [27:0] ref_length_in;
  logic [27:0] ref_addr_in;
  logic [15:0] query_length_in;
  logic [15:0] query_id_in;
  logic [31:0] cell_score_threshold_in;
  logic query_info_valid_in;
  logic query_info_rdy_out;
  logic [NUM_PES*2-1:0] query_seq_block_in;
  logic query_seq_block_valid_in;
  logic query_seq_block_rdy_out;
  logic [27:0] eng_ref_length_out;
  logic [27:0] eng_ref_addr_out;
  logic [15:0] eng_query_length_out;
  logic [15:0] eng_query_id_out;
  logic [31:0] eng_cell_score_threshold_out;
  logic [NUM_PES*2-1:0] eng_query_seq_block_out;
  logic [NUM_ENGINES-1:0] eng_info_valid_out;
  logic [NUM_ENGINES-1:0] eng_info_rdy_in;
  logic [NUM_ENGINES-1:0] eng_seq_block_valid_out;
  logic [NUM_ENGINES-1:0] eng_seq_block_rdy_in;
  logic [NUM_ENGINES-1:0] eng_done_in;
  logic [NUM_ENGINES-1:0] eng_busy_out;
  logic [ENG_IDX_W-1:0] active_engine_out;
  logic protocol_err_out;
  modport slave (
    input ref_length_in, ref_addr_in, query_length_in, query_id_in, cell_score_threshold_in,
    input query_info_valid_in, query_seq_block_in, query_seq_block_valid_in,
    input eng_info_rdy_in, eng_seq_block_rdy_in, eng_done_in,
    output query_info_rdy_out, query_seq_block_rdy_out,
    output eng_ref_length_out, eng_ref_addr_out, eng_query_length_out, eng_query_id_out,
    output eng_cell_score_threshold_out, eng_query_seq_block_out,
    output eng_info_valid_out, eng_seq_block_valid_out, eng_busy_out, active_engine_out, protocol_err_out
  );
  modport master (
    output ref_length_in, ref_addr_in, query_length_in, query_id_in, cell_score_threshold_in,
    output query_info_valid_in, query_seq_block_in, query_seq_block_valid_in,
    output eng_info_rdy_in, eng_seq_block_rdy_in, eng_done_in,
    input query_info_rdy_out, query_seq_block_rdy_out,
    input eng_ref_length_out, eng_ref_addr_out, eng_query_length_out, eng_query_id_out,
    input eng_cell_score_threshold_out, eng_query_seq_block_out,
    input eng_info_valid_out, eng_seq_block_valid_out, eng_busy_out, active_engine_out, protocol_err_out
  );
endinterface

// File: rtl/query_dispatcher.sv
// query_dispatcher: round-robin query scheduler; ports clk, rst (sync, active-high), bus (query_dispatcher_if.slave: upstream info/block handshakes, per-engine one-hot valids, readies, done pulses, busy flags, active engine, sticky protocol error)
module query_dispatcher #(
  parameter int NUM_ENGINES = 4,
  parameter int ENG_IDX_W = 2,
  parameter int NUM_PES = 64
) (
  input logic clk,
  input logic rst,
  query_dispatcher_if.slave bus
);
  localparam int PW = $clog2(NUM_PES);
  localparam int CW = 17 - PW;
  typedef enum logic [1:0] {IDLE, SEND_INFO, SEND_BLOCKS} state_t;
  state_t state_q, state_d;
  logic [NUM_ENGINES-1:0] busy_q, busy_d, sel_oh, done_ok;
  logic [ENG_IDX_W-1:0] rr_q, rr_d, sel_q, sel_d, pick, idx;
  logic [CW-1:0] cnt_q, cnt_d, nb_q, nb_d;
  logic err_q, err_d, found, info_hs, blk_hs;
  assign sel_oh = NUM_ENGINES'(1) << sel_q;
  assign done_ok = bus.eng_done_in & ~((state_q != IDLE) ? sel_oh : '0);
  assign info_hs = state_q == SEND_INFO && bus.query_info_valid_in && bus.eng_info_rdy_in[sel_q];
  assign blk_hs = state_q == SEND_BLOCKS && bus.query_seq_block_valid_in && bus.eng_seq_block_rdy_in[sel_q];
  always_comb begin
    found = 1'b0;
    pick = '0;
    idx = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      idx = ENG_IDX_W'((int'(rr_q) + k) % NUM_ENGINES);
      if (!found && !busy_q[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    busy_d = busy_q & ~done_ok;
    rr_d = rr_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    nb_d = nb_q;
    err_d = err_q | (state_q != IDLE && bus.eng_done_in[sel_q]);
    case (state_q)
      IDLE: if (bus.query_info_valid_in && found) begin
        state_d = SEND_INFO;
        sel_d = pick;
        busy_d[pick] = 1'b1;
        rr_d = (pick == ENG_IDX_W'(NUM_ENGINES - 1)) ? '0 : pick + 1'b1;
        nb_d = CW'(bus.query_length_in >> PW) + CW'(|bus.query_length_in[PW-1:0]);
        cnt_d = '0;
      end
      SEND_INFO: if (info_hs) state_d = (nb_q == '0) ? IDLE : SEND_BLOCKS;
      SEND_BLOCKS: if (blk_hs) begin
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == nb_q - 1'b1) ? IDLE : SEND_BLOCKS;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q <= '0;
      rr_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
      nb_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      rr_q <= rr_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      nb_q <= nb_d;
      err_q <= err_d;
    end
  end
  assign bus.eng_ref_length_out = bus.ref_length_in;
  assign bus.eng_ref_addr_out = bus.ref_addr_in;
  assign bus.eng_query_length_out = bus.query_length_in;
  assign bus.eng_query_id_out = bus.query_id_in;
  assign bus.eng_cell_score_threshold_out = bus.cell_score_threshold_in;
  assign bus.eng_query_seq_block_out = bus.query_seq_block_in;
  assign bus.eng_info_valid_out = (state_q == SEND_INFO && bus.query_info_valid_in) ? sel_oh : '0;
  assign bus.eng_seq_block_valid_out = (state_q == SEND_BLOCKS && bus.query_seq_block_valid_in) ? sel_oh : '0;
  assign bus.query_info_rdy_out = state_q == SEND_INFO && bus.eng_info_rdy_in[sel_q];
  assign bus.query_seq_block_rdy_out = state_q == SEND_BLOCKS && bus.eng_seq_block_rdy_in[sel_q];
  assign bus.eng_busy_out = busy_q;
  assign bus.active_engine_out = sel_q;
  assign bus.protocol_err_out = err_q;
endmodule

// File: tb/tb_query_dispatcher.sv
// tb_query_dispatcher: directed self-checking bench for query_dispatcher
module tb_query_dispatcher;
  localparam int NE = 4;
  localparam int IW = 2;
  localparam int NP = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int info_cnt[NE];
  int blk_cnt[NE];
  int blk_vld[NE];
  int last_eng = -1;
  always #5 clk = ~clk;
  query_dispatcher_if #(.NUM_ENGINES(NE), .ENG_IDX_W(IW), .NUM_PES(NP)) ifc ();
  query_dispatcher #(.NUM_ENGINES(NE), .ENG_IDX_W(IW), .NUM_PES(NP)) dut (.clk(clk), .rst(rst), .bus(ifc));
  always @(posedge clk) begin
    for (int i = 0; i < NE; i++) begin
      if (ifc.eng_info_valid_out[i] && ifc.eng_info_rdy_in[i]) begin
        info_cnt[i] <= info_cnt[i] + 1;
        last_eng <= i;
      end
      if (ifc.eng_seq_block_valid_out[i] && ifc.eng_seq_block_rdy_in[i]) blk_cnt[i] <= blk_cnt[i] + 1;
      if (ifc.eng_seq_block_valid_out[i]) blk_vld[i] <= blk_vld[i] + 1;
    end
  end
  task automatic clear_inputs();
    ifc.ref_length_in = 28'd10;
    ifc.ref_addr_in = 28'h100;
    ifc.query_length_in = '0;
    ifc.query_id_in = '0;
    ifc.cell_score_threshold_in = 32'd50;
    ifc.query_info_valid_in = 1'b0;
    ifc.query_seq_block_in = '0;
    ifc.query_seq_block_valid_in = 1'b0;
    ifc.eng_info_rdy_in = '1;
    ifc.eng_seq_block_rdy_in = '1;
    ifc.eng_done_in = '0;
  endtask
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic send_info(input logic [15:0] len, output logic ok);
    int t;
    ok = 1'b1;
    t = 0;
    @(negedge clk);
    ifc.query_length_in = len;
    ifc.query_id_in = len;
    ifc.query_info_valid_in = 1'b1;
    #1;
    while (!ifc.query_info_rdy_out) begin
      t++;
      if (t > 40) begin
        ok = 1'b0;
        break;
      end
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    ifc.query_info_valid_in = 1'b0;
  endtask
  task automatic send_blocks(input int n, output logic ok);
    int t;
    ok = 1'b1;
    for (int b = 0; b < n && ok; b++) begin
      ifc.query_seq_block_in = 128'(b + 1);
      ifc.query_seq_block_valid_in = 1'b1;
      #1;
      t = 0;
      while (!ifc.query_seq_block_rdy_out) begin
        t++;
        if (t > 40) begin
          ok = 1'b0;
          break;
        end
        @(negedge clk);
        #1;
      end
      @(negedge clk);
    end
    ifc.query_seq_block_valid_in = 1'b0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    ifc.query_info_valid_in = 1'b1;
    ifc.query_seq_block_valid_in = 1'b1;
    ifc.query_length_in = 16'h1234;
    ifc.query_seq_block_in = 128'hABCD;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (ifc.eng_busy_out !== 4'b0) begin $display("FAIL reset_busy: got %b exp 0000", ifc.eng_busy_out); fails++; end
    tests++; if (ifc.eng_info_valid_out !== 4'b0 || ifc.eng_seq_block_valid_out !== 4'b0) begin $display("FAIL reset_valid: got %b/%b exp 0000/0000", ifc.eng_info_valid_out, ifc.eng_seq_block_valid_out); fails++; end
    tests++; if (ifc.query_info_rdy_out !== 1'b0 || ifc.query_seq_block_rdy_out !== 1'b0) begin $display("FAIL reset_rdy: got %b%b exp 00", ifc.query_info_rdy_out, ifc.query_seq_block_rdy_out); fails++; end
    tests++; if (ifc.protocol_err_out !== 1'b0 || ifc.active_engine_out !== 2'd0) begin $display("FAIL reset_err_active: got %b/%0d exp 0/0", ifc.protocol_err_out, ifc.active_engine_out); fails++; end
    tests++; if (ifc.eng_query_length_out !== 16'h1234 || ifc.eng_query_seq_block_out !== 128'hABCD) begin $display("FAIL passthrough: got %h/%h exp 1234/abcd", ifc.eng_query_length_out, ifc.eng_query_seq_block_out); fails++; end
    ifc.query_info_valid_in = 1'b0;
    ifc.query_seq_block_valid_in = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    tests++; if (ifc.eng_busy_out !== 4'b0 || dut.state_q !== 2'd0) begin $display("FAIL post_reset_idle: busy %b state %0d exp 0000/0", ifc.eng_busy_out, dut.state_q); fails++; end
  endtask
  task automatic test_basic();
    logic ok1, ok2;
    int i0, b0;
    apply_reset();
    i0 = info_cnt[0];
    b0 = blk_cnt[0];
    send_info(16'd130, ok1);
    send_blocks(3, ok2);
    #1;
    tests++; if ({ok1, ok2} !== 2'b11) begin $display("FAIL basic_handshake: got %b exp 11", {ok1, ok2}); fails++; end
    tests++; if (info_cnt[0] - i0 !== 1) begin $display("FAIL basic_info: got %0d exp 1", info_cnt[0] - i0); fails++; end
    tests++; if (blk_cnt[0] - b0 !== 3) begin $display("FAIL basic_blocks: got %0d exp 3", blk_cnt[0] - b0); fails++; end
    tests++; if (ifc.eng_busy_out !== 4'b0001) begin $display("FAIL basic_busy: got %b exp 0001", ifc.eng_busy_out); fails++; end
    tests++; if (ifc.active_engine_out !== 2'd0) begin $display("FAIL basic_active: got %0d exp 0", ifc.active_engine_out); fails++; end
    tests++; if (dut.state_q !== 2'd0 || dut.rr_q !== 2'd1) begin $display("FAIL basic_idle_rr: state %0d rr %0d exp 0/1", dut.state_q, dut.rr_q); fails++; end
  endtask
  task automatic test_back_to_back();
    logic ok1, ok2;
    logic seen;
    apply_reset();
    for (int q = 0; q < NE; q++) begin
      send_info(16'd64, ok1);
      send_blocks(1, ok2);
      tests++; if (last_eng !== q || {ok1, ok2} !== 2'b11) begin $display("FAIL b2b_order%0d: eng %0d ok %b exp %0d/11", q, last_eng, {ok1, ok2}, q); fails++; end
    end
    #1;
    tests++; if (ifc.eng_busy_out !== 4'b1111) begin $display("FAIL b2b_busy: got %b exp 1111", ifc.eng_busy_out); fails++; end
    @(negedge clk);
    ifc.query_length_in = 16'd64;
    ifc.query_info_valid_in = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      #1;
      if (ifc.query_info_rdy_out || ifc.eng_info_valid_out != 4'b0) seen = 1'b1;
      @(negedge clk);
    end
    tests++; if (seen !== 1'b0) begin $display("FAIL b2b_stall: rdy/valid seen %b exp 0", seen); fails++; end
    ifc.eng_done_in = 4'b0100;
    @(negedge clk);
    ifc.eng_done_in = 4'b0000;
    send_info(16'd64, ok1);
    send_blocks(1, ok2);
    #1;
    tests++; if (last_eng !== 2 || {ok1, ok2} !== 2'b11) begin $display("FAIL b2b_fifth: eng %0d ok %b exp 2/11", last_eng, {ok1, ok2}); fails++; end
    tests++; if (ifc.eng_busy_out !== 4'b1111 || ifc.active_engine_out !== 2'd2) begin $display("FAIL b2b_fifth_busy: busy %b active %0d exp 1111/2", ifc.eng_busy_out, ifc.active_engine_out); fails++; end
  endtask
  task automatic test_lengths();
    logic ok1, ok2;
    int s[NE];
    apply_reset();
    s = blk_cnt;
    send_info(16'd0, ok1);
    #1;
    tests++; if (dut.state_q !== 2'd0 || !ok1) begin $display("FAIL len0_idle: state %0d ok %b exp 0/1", dut.state_q, ok1); fails++; end
    repeat (2) @(negedge clk);
    tests++; if (blk_cnt[0] !== s[0] || last_eng !== 0) begin $display("FAIL len0_blocks: got %0d eng %0d exp 0/0", blk_cnt[0] - s[0], last_eng); fails++; end
    send_info(16'd64, ok1);
    send_blocks(1, ok2);
    #1;
    tests++; if (blk_cnt[1] - s[1] !== 1 || dut.state_q !== 2'd0 || {ok1, ok2} !== 2'b11) begin $display("FAIL len64: blocks %0d state %0d ok %b exp 1/0/11", blk_cnt[1] - s[1], dut.state_q, {ok1, ok2}); fails++; end
    send_info(16'd65, ok1);
    send_blocks(2, ok2);
    #1;
    tests++; if (blk_cnt[2] - s[2] !== 2 || dut.state_q !== 2'd0 || {ok1, ok2} !== 2'b11) begin $display("FAIL len65: blocks %0d state %0d ok %b exp 2/0/11", blk_cnt[2] - s[2], dut.state_q, {ok1, ok2}); fails++; end
    tests++; if (ifc.eng_busy_out !== 4'b0111) begin $display("FAIL len_busy: got %b exp 0111", ifc.eng_busy_out); fails++; end
  endtask
  task automatic test_toggle();
    logic ok1;
    int s[NE];
    int v[NE];
    int hs, mism;
    apply_reset();
    send_info(16'd320, ok1);
    s = blk_cnt;
    v = blk_vld;
    hs = 0;
    mism = 0;
    ifc.query_seq_block_valid_in = 1'b1;
    for (int c = 0; c < 40; c++) begin
      ifc.eng_seq_block_rdy_in[0] = ~ifc.eng_seq_block_rdy_in[0];
      #1;
      if (ifc.query_seq_block_rdy_out !== ifc.eng_seq_block_rdy_in[0]) mism++;
      if (ifc.query_seq_block_rdy_out) hs++;
      if (hs == 5) break;
      @(negedge clk);
    end
    @(negedge clk);
    ifc.query_seq_block_valid_in = 1'b0;
    ifc.eng_seq_block_rdy_in = '1;
    #1;
    tests++; if (mism !== 0 || hs !== 5 || !ok1) begin $display("FAIL toggle_mirror: mism %0d hs %0d ok %b exp 0/5/1", mism, hs, ok1); fails++; end
    tests++; if (blk_cnt[0] - s[0] !== 5) begin $display("FAIL toggle_count: got %0d exp 5", blk_cnt[0] - s[0]); fails++; end
    tests++; if (blk_vld[1] - v[1] + blk_vld[2] - v[2] + blk_vld[3] - v[3] !== 0) begin $display("FAIL toggle_stray: got %0d exp 0", blk_vld[1] - v[1] + blk_vld[2] - v[2] + blk_vld[3] - v[3]); fails++; end
    tests++; if (dut.state_q !== 2'd0) begin $display("FAIL toggle_idle: got %0d exp 0", dut.state_q); fails++; end
  endtask
  task automatic test_protocol();
    logic ok1;
    apply_reset();
    send_info(16'd320, ok1);
    ifc.eng_done_in = 4'b0100;
    @(negedge clk);
    ifc.eng_done_in = 4'b0000;
    #1;
    tests++; if (ifc.protocol_err_out !== 1'b0 || ifc.eng_busy_out !== 4'b0001 || !ok1) begin $display("FAIL idle_done: err %b busy %b exp 0/0001", ifc.protocol_err_out, ifc.eng_busy_out); fails++; end
    ifc.eng_done_in = 4'b0001;
    @(negedge clk);
    ifc.eng_done_in = 4'b0000;
    #1;
    tests++; if (ifc.protocol_err_out !== 1'b1 || ifc.eng_busy_out !== 4'b0001) begin $display("FAIL sel_done: err %b busy %b exp 1/0001", ifc.protocol_err_out, ifc.eng_busy_out); fails++; end
    repeat (3) @(negedge clk);
    #1;
    tests++; if (ifc.protocol_err_out !== 1'b1 || dut.state_q !== 2'd2) begin $display("FAIL err_sticky: err %b state %0d exp 1/2", ifc.protocol_err_out, dut.state_q); fails++; end
  endtask
  task automatic test_reset_mid();
    logic ok1, ok2;
    apply_reset();
    send_info(16'd256, ok1);
    send_blocks(2, ok2);
    #1;
    tests++; if (dut.state_q !== 2'd2 || {ok1, ok2} !== 2'b11) begin $display("FAIL mid_before: state %0d ok %b exp 2/11", dut.state_q, {ok1, ok2}); fails++; end
    @(negedge clk);
    rst = 1'b1;
    ifc.query_info_valid_in = 1'b1;
    ifc.query_seq_block_valid_in = 1'b1;
    @(negedge clk);
    #1;
    tests++; if (dut.state_q !== 2'd0 || ifc.eng_busy_out !== 4'b0 || dut.rr_q !== 2'd0) begin $display("FAIL mid_state: state %0d busy %b rr %0d exp 0/0000/0", dut.state_q, ifc.eng_busy_out, dut.rr_q); fails++; end
    tests++; if ({ifc.eng_info_valid_out, ifc.eng_seq_block_valid_out, ifc.query_info_rdy_out, ifc.query_seq_block_rdy_out} !== 10'b0) begin $display("FAIL mid_handshake: got %b exp 0", {ifc.eng_info_valid_out, ifc.eng_seq_block_valid_out, ifc.query_info_rdy_out, ifc.query_seq_block_rdy_out}); fails++; end
    rst = 1'b0;
    clear_inputs();
  endtask
  initial begin
    clear_inputs();
    test_reset();
    test_basic();
    test_back_to_back();
    test_lengths();
    test_toggle();
    test_protocol();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
